// File: rtl/result_pkg.sv
// Shared select encodings and capture decode for the writeback result-hold buffer.
package result_pkg;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_SRC_A = 2'b01;
  localparam logic [1:0] SEL_SRC_B = 2'b10;
  localparam logic [1:0] SEL_RSVD  = 2'b11;

  // Only the two producing sources capture; NONE and the reserved code never do.
  function automatic logic is_capture(input logic [1:0] sel);
    return (sel == SEL_SRC_A) || (sel == SEL_SRC_B);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; count kept separately so full/empty never alias.
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full, w_empty, w_pop, w_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // flush wins over both ports; a pop frees the slot a same-cycle push needs when full
  assign w_pop   = i_pop && !w_empty && !i_flush;
  assign w_push  = i_push && (!w_full || w_pop) && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/result_hold_buf.sv
// Writeback result-hold stage: stable last-captured value plus a drainable FIFO of every capture.
module result_hold_buf
  import result_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int HOLD_ZERO = 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] result,
  input  logic [1:0]       s,
  input  logic             flush,
  output logic [WIDTH-1:0] held,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             overflow
);

  logic             w_capture, w_pop, w_empty, w_full, w_hold_upd;
  logic [WIDTH-1:0] r_held;
  logic             r_overflow;

  assign w_capture  = is_capture(s);
  assign w_pop      = out_valid && out_ready;
  // zero results still enter the FIFO; they only skip the held register
  assign w_hold_upd = w_capture && !((HOLD_ZERO != 0) && (result == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_held <= '0;
    else if (w_hold_upd) r_held <= result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_overflow <= 1'b0;
    else if (flush)                          r_overflow <= 1'b0;
    else if (w_capture && w_full && !w_pop)  r_overflow <= 1'b1;
  end

  result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_capture),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_wdata (result),
    .o_rdata (out_data),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign held      = r_held;
  assign out_valid = !w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_result_hold_buf.sv
// Directed vector bench for result_hold_buf (DEPTH=4), with a HOLD_ZERO=0 twin for held.
module tb_result_hold_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] result = '0;
  logic [1:0]  s = 2'b00;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] held, out_data, held0, out_data0;
  logic        out_valid, full, overflow, out_valid0, full0, overflow0;
  logic [2:0]  count, count0;

  int total = 0;
  int bad   = 0;

  result_hold_buf #(.WIDTH(32), .DEPTH(4), .HOLD_ZERO(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .result(result), .s(s), .flush(flush),
    .held(held), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .overflow(overflow));

  result_hold_buf #(.WIDTH(32), .DEPTH(4), .HOLD_ZERO(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .result(result), .s(s), .flush(flush),
    .held(held0), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .count(count0), .full(full0), .overflow(overflow0));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  s;
    logic [31:0] res;
    logic        rdy;
    logic        fl;
    logic [31:0] held;
    logic [31:0] held0;
    logic [2:0]  cnt;
    logic        vld;
    logic [31:0] data;
    logic        full;
    logic        ovf;
  } vec_t;

  function automatic vec_t mk(logic [1:0] s_i, logic [31:0] r_i, logic rdy_i, logic fl_i,
                              logic [31:0] h_i, logic [31:0] h0_i, logic [2:0] c_i,
                              logic v_i, logic [31:0] d_i, logic f_i, logic o_i);
    vec_t v;
    v.s = s_i; v.res = r_i; v.rdy = rdy_i; v.fl = fl_i; v.held = h_i; v.held0 = h0_i;
    v.cnt = c_i; v.vld = v_i; v.data = d_i; v.full = f_i; v.ovf = o_i;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [31:0] eh, input logic [31:0] eh0,
                         input logic [2:0] ec, input logic ev, input logic [31:0] ed,
                         input logic ef, input logic eo);
    chk("held", idx, held, eh);
    chk("held_hz0", idx, held0, eh0);
    chk("count", idx, 32'(count), 32'(ec));
    chk("out_valid", idx, 32'(out_valid), 32'(ev));
    chk("out_data", idx, out_data, ed);
    chk("full", idx, 32'(full), 32'(ef));
    chk("overflow", idx, 32'(overflow), 32'(eo));
  endtask

  vec_t vt[32];

  initial begin
    // capture and drain
    vt[0]  = mk(2'b01, 32'h11, 0, 0, 32'h11, 32'h11, 1, 1, 32'h11, 0, 0);
    vt[1]  = mk(2'b10, 32'h22, 0, 0, 32'h22, 32'h22, 2, 1, 32'h11, 0, 0);
    vt[2]  = mk(2'b00, 32'h0,  0, 0, 32'h22, 32'h22, 2, 1, 32'h11, 0, 0);
    vt[3]  = mk(2'b00, 32'h0,  1, 0, 32'h22, 32'h22, 1, 1, 32'h22, 0, 0);
    vt[4]  = mk(2'b00, 32'h0,  1, 0, 32'h22, 32'h22, 0, 0, 32'h0,  0, 0);
    vt[5]  = mk(2'b00, 32'h0,  0, 0, 32'h22, 32'h22, 0, 0, 32'h0,  0, 0);
    // zero result: queued, but held only changes when HOLD_ZERO=0
    vt[6]  = mk(2'b01, 32'h0,  0, 0, 32'h22, 32'h0,  1, 1, 32'h0,  0, 0);
    vt[7]  = mk(2'b10, 32'h33, 0, 0, 32'h33, 32'h33, 2, 1, 32'h0,  0, 0);
    vt[8]  = mk(2'b00, 32'h0,  1, 0, 32'h33, 32'h33, 1, 1, 32'h33, 0, 0);
    vt[9]  = mk(2'b00, 32'h0,  1, 0, 32'h33, 32'h33, 0, 0, 32'h0,  0, 0);
    // empty + capture + ready: no bypass
    vt[10] = mk(2'b01, 32'h44, 1, 0, 32'h44, 32'h44, 1, 1, 32'h44, 0, 0);
    vt[11] = mk(2'b00, 32'h0,  1, 0, 32'h44, 32'h44, 0, 0, 32'h0,  0, 0);
    // fill, overflow, push+pop while full
    vt[12] = mk(2'b01, 32'hA1, 0, 0, 32'hA1, 32'hA1, 1, 1, 32'hA1, 0, 0);
    vt[13] = mk(2'b10, 32'hA2, 0, 0, 32'hA2, 32'hA2, 2, 1, 32'hA1, 0, 0);
    vt[14] = mk(2'b01, 32'hA3, 0, 0, 32'hA3, 32'hA3, 3, 1, 32'hA1, 0, 0);
    vt[15] = mk(2'b10, 32'hA4, 0, 0, 32'hA4, 32'hA4, 4, 1, 32'hA1, 1, 0);
    vt[16] = mk(2'b01, 32'hA5, 0, 0, 32'hA5, 32'hA5, 4, 1, 32'hA1, 1, 1);
    vt[17] = mk(2'b10, 32'hA6, 1, 0, 32'hA6, 32'hA6, 4, 1, 32'hA2, 1, 1);
    // non-capture selects
    vt[18] = mk(2'b11, 32'hFFFF_FFFF, 0, 0, 32'hA6, 32'hA6, 4, 1, 32'hA2, 1, 1);
    vt[19] = mk(2'b00, 32'hFFFF_FFFF, 0, 0, 32'hA6, 32'hA6, 4, 1, 32'hA2, 1, 1);
    vt[20] = mk(2'b11, 32'hFFFF_FFFF, 0, 0, 32'hA6, 32'hA6, 4, 1, 32'hA2, 1, 1);
    vt[21] = mk(2'b00, 32'hFFFF_FFFF, 0, 0, 32'hA6, 32'hA6, 4, 1, 32'hA2, 1, 1);
    vt[22] = mk(2'b11, 32'hFFFF_FFFF, 0, 0, 32'hA6, 32'hA6, 4, 1, 32'hA2, 1, 1);
    // drain; overflow stays sticky
    vt[23] = mk(2'b00, 32'h0,  1, 0, 32'hA6, 32'hA6, 3, 1, 32'hA3, 0, 1);
    vt[24] = mk(2'b00, 32'h0,  1, 0, 32'hA6, 32'hA6, 2, 1, 32'hA4, 0, 1);
    vt[25] = mk(2'b00, 32'h0,  1, 0, 32'hA6, 32'hA6, 1, 1, 32'hA6, 0, 1);
    vt[26] = mk(2'b00, 32'h0,  1, 0, 32'hA6, 32'hA6, 0, 0, 32'h0,  0, 1);
    // flush with count=3 and coincident capture
    vt[27] = mk(2'b01, 32'hB1, 0, 0, 32'hB1, 32'hB1, 1, 1, 32'hB1, 0, 1);
    vt[28] = mk(2'b10, 32'hB2, 0, 0, 32'hB2, 32'hB2, 2, 1, 32'hB1, 0, 1);
    vt[29] = mk(2'b01, 32'hB3, 0, 0, 32'hB3, 32'hB3, 3, 1, 32'hB1, 0, 1);
    vt[30] = mk(2'b01, 32'h55, 0, 1, 32'h55, 32'h55, 0, 0, 32'h0,  0, 0);
    vt[31] = mk(2'b00, 32'h0,  0, 0, 32'h55, 32'h55, 0, 0, 32'h0,  0, 0);

    // reset held low for three edges, then check idle state
    repeat (3) @(posedge clk);
    #1;
    chk_all(-1, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      s = vt[i].s; result = vt[i].res; out_ready = vt[i].rdy; flush = vt[i].fl;
      @(posedge clk);
      #1;
      chk_all(i, vt[i].held, vt[i].held0, vt[i].cnt, vt[i].vld, vt[i].data, vt[i].full, vt[i].ovf);
    end

    // async reset mid-drain: two entries, pop one, then pull rst_n between edges
    s = 2'b01; result = 32'hC1; out_ready = 1'b0;
    @(posedge clk); #1;
    s = 2'b10; result = 32'hC2;
    @(posedge clk); #1;
    s = 2'b00; result = 32'h0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk_all(100, 32'hC2, 32'hC2, 3'd1, 1'b1, 32'hC2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all(101, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    s = 2'b10; result = 32'hD1; out_ready = 1'b0;
    @(posedge clk); #1;
    chk_all(102, 32'hD1, 32'hD1, 3'd1, 1'b1, 32'hD1, 1'b0, 1'b0);
    s = 2'b00;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
